// File: rtl/poly_wavetable_synth.sv
// poly_wavetable_synth: NUM_VOICES phase accumulators share one registered
// sine ROM. They are walked once per sample_tick, summed and scaled into one
// signed sample.
// Optional build macro POLY_SYNTH_LINEAR_INTERP_EN: linear interpolation
// between adjacent table entries, using one extra ROM read per voice.
// sample_tick is captured on the edge that samples it (config snapshot, busy
// set) and the FSM leaves IDLE on the following edge. out_valid therefore
// rises 2*NUM_VOICES+2 edges (3*NUM_VOICES+2 with interpolation) after that
// edge.
// The ROM is a 65-entry quarter wave of a 256-entry table; TABLE_AW must be
// in 2..8.
module poly_wavetable_synth #(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 24,
   parameter int TABLE_AW   = 8,
   parameter int SAMPLE_W   = 16,
   localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                sample_tick,
   input  logic                voice_we,
   input  logic [VW-1:0]       voice_sel,
   input  logic [PHASE_W-1:0]  voice_freq,
   input  logic                voice_en,
   output logic [SAMPLE_W-1:0] out,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int SHIFT = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + SHIFT;
   localparam int EXT_W = (SAMPLE_W > 16) ? SAMPLE_W : 16;
   localparam int UP    = (SAMPLE_W > 16) ? SAMPLE_W - 16 : 0;
   localparam int DN    = (SAMPLE_W < 16) ? 16 - SAMPLE_W : 0;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_INTERP, S_ACCUM, S_DONE} state_t;

   // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64
   function automatic logic [15:0] quarter_sine(input logic [6:0] j);
      logic [15:0] r;
      case (j)
         7'd0:  r = 16'd0;     7'd1:  r = 16'd804;   7'd2:  r = 16'd1608;  7'd3:  r = 16'd2410;
         7'd4:  r = 16'd3212;  7'd5:  r = 16'd4011;  7'd6:  r = 16'd4808;  7'd7:  r = 16'd5602;
         7'd8:  r = 16'd6393;  7'd9:  r = 16'd7179;  7'd10: r = 16'd7962;  7'd11: r = 16'd8739;
         7'd12: r = 16'd9512;  7'd13: r = 16'd10278; 7'd14: r = 16'd11039; 7'd15: r = 16'd11793;
         7'd16: r = 16'd12539; 7'd17: r = 16'd13279; 7'd18: r = 16'd14010; 7'd19: r = 16'd14732;
         7'd20: r = 16'd15446; 7'd21: r = 16'd16151; 7'd22: r = 16'd16846; 7'd23: r = 16'd17530;
         7'd24: r = 16'd18204; 7'd25: r = 16'd18868; 7'd26: r = 16'd19519; 7'd27: r = 16'd20159;
         7'd28: r = 16'd20787; 7'd29: r = 16'd21403; 7'd30: r = 16'd22005; 7'd31: r = 16'd22594;
         7'd32: r = 16'd23170; 7'd33: r = 16'd23731; 7'd34: r = 16'd24279; 7'd35: r = 16'd24811;
         7'd36: r = 16'd25329; 7'd37: r = 16'd25832; 7'd38: r = 16'd26319; 7'd39: r = 16'd26790;
         7'd40: r = 16'd27245; 7'd41: r = 16'd27683; 7'd42: r = 16'd28105; 7'd43: r = 16'd28510;
         7'd44: r = 16'd28898; 7'd45: r = 16'd29268; 7'd46: r = 16'd29621; 7'd47: r = 16'd29956;
         7'd48: r = 16'd30273; 7'd49: r = 16'd30571; 7'd50: r = 16'd30852; 7'd51: r = 16'd31113;
         7'd52: r = 16'd31356; 7'd53: r = 16'd31580; 7'd54: r = 16'd31785; 7'd55: r = 16'd31971;
         7'd56: r = 16'd32137; 7'd57: r = 16'd32285; 7'd58: r = 16'd32412; 7'd59: r = 16'd32521;
         7'd60: r = 16'd32609; 7'd61: r = 16'd32678; 7'd62: r = 16'd32728; 7'd63: r = 16'd32757;
         7'd64: r = 16'd32767;
         default: r = 16'd0;
      endcase
      return r;
   endfunction

   // Full-wave table entry from quadrant symmetry, rescaled to SAMPLE_W
   function automatic logic signed [SAMPLE_W-1:0] sine_at(input logic [TABLE_AW-1:0] a);
      logic [7:0]              i8;
      logic [6:0]              j;
      logic [15:0]             mag;
      logic signed [EXT_W-1:0] w;
      i8  = 8'(a) << (8 - TABLE_AW);
      j   = i8[6] ? (7'd64 - {1'b0, i8[5:0]}) : {1'b0, i8[5:0]};
      mag = quarter_sine(j);
      w   = EXT_W'(signed'(i8[7] ? (16'd0 - mag) : mag));
      return SAMPLE_W'((w <<< UP) >>> DN);
   endfunction

   state_t                     state_q, state_d;
   logic [VW-1:0]              v_q, v_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]         phase_d [NUM_VOICES];
   logic [PHASE_W-1:0]         inc_q [NUM_VOICES];
   logic [PHASE_W-1:0]         inc_d [NUM_VOICES];
   logic [PHASE_W-1:0]         wrk_inc_q [NUM_VOICES];
   logic [PHASE_W-1:0]         wrk_inc_d [NUM_VOICES];
   logic [NUM_VOICES-1:0]      en_q, en_d, wrk_en_q, wrk_en_d;
   logic                       start_q, start_d;
   logic                       busy_q, busy_d;
   logic [SAMPLE_W-1:0]        out_q, out_d;
   logic                       out_valid_q, out_valid_d;
   logic                       overrun_q, overrun_d;
   logic [TABLE_AW-1:0]        rom_addr;
   logic signed [SAMPLE_W-1:0] rom_data_q, rom_data_d;
`ifdef POLY_SYNTH_LINEAR_INTERP_EN
   logic signed [SAMPLE_W-1:0] lo_q, lo_d;
`endif

   // Next-state logic: config writes, tick capture/overrun, frame sequencing
   // NOTE: every *_d gets a default before any branch so no latch is inferred.
   always_comb begin
      logic [TABLE_AW-1:0]        idx;
      logic signed [SAMPLE_W-1:0] contrib;
      state_d     = state_q;
      v_d         = v_q;
      acc_d       = acc_q;
      phase_d     = phase_q;
      inc_d       = inc_q;
      en_d        = en_q;
      wrk_inc_d   = wrk_inc_q;
      wrk_en_d    = wrk_en_q;
      start_d     = start_q;
      busy_d      = busy_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      idx         = phase_q[v_q][PHASE_W-1 -: TABLE_AW];
      rom_addr    = idx;
      contrib     = rom_data_q;
`ifdef POLY_SYNTH_LINEAR_INTERP_EN
      lo_d = lo_q;
      begin
         logic [7:0]                 frac;
         logic signed [SAMPLE_W:0]   diff;
         logic signed [SAMPLE_W+9:0] prod;
         frac    = phase_q[v_q][PHASE_W-TABLE_AW-1 -: 8];
         diff    = $signed({rom_data_q[SAMPLE_W-1], rom_data_q}) - $signed({lo_q[SAMPLE_W-1], lo_q});
         prod    = (SAMPLE_W+10)'(diff) * $signed({{(SAMPLE_W+2){1'b0}}, frac});
         contrib = SAMPLE_W'((SAMPLE_W+10)'(lo_q) + (prod >>> 8));
      end
`endif

      if (voice_we) begin
         inc_d[voice_sel] = voice_freq;
         en_d[voice_sel]  = voice_en;
      end

      // Snapshot reads the *_q copies, so a same-edge write lands next frame.
      if (sample_tick) begin
         if (busy_q) begin
            overrun_d = 1'b1;
         end else begin
            busy_d    = 1'b1;
            start_d   = 1'b1;
            wrk_inc_d = inc_q;
            wrk_en_d  = en_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_q) begin
               start_d = 1'b0;
               acc_d   = '0;
               v_d     = '0;
               state_d = S_FETCH;
            end
         end
`ifdef POLY_SYNTH_LINEAR_INTERP_EN
         S_FETCH: state_d = S_INTERP;
         S_INTERP: begin
            lo_d     = rom_data_q;
            rom_addr = idx + 1'b1;
            state_d  = S_ACCUM;
         end
`else
         S_FETCH: state_d = S_ACCUM;
`endif
         S_ACCUM: begin
            if (wrk_en_q[v_q]) begin
               acc_d        = acc_q + ACC_W'(contrib);
               phase_d[v_q] = phase_q[v_q] + wrk_inc_q[v_q];
            end
            if (v_q == VW'(NUM_VOICES - 1)) begin
               state_d = S_DONE;
            end else begin
               v_d     = v_q + VW'(1);
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            out_d       = SAMPLE_W'(acc_q >>> SHIFT);
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Disabling a voice restarts its phase; this wins over an advance.
      if (voice_we && !voice_en) begin
         phase_d[voice_sel] = '0;
      end
   end

   // ROM data register; rom_data_d is the table entry at rom_addr
   always_comb rom_data_d = sine_at(rom_addr);

   // Registered ROM read
   // NOTE: no reset here -- the data is only consumed after FETCH loads it, and a resetless ROM register maps onto block RAM output registers.
   always_ff @(posedge Clk) begin
      rom_data_q <= rom_data_d;
   end

   // State, configuration and output registers
   // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_IDLE;
         v_q         <= '0;
         acc_q       <= '0;
         en_q        <= '0;
         wrk_en_q    <= '0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            phase_q[i]   <= '0;
            inc_q[i]     <= '0;
            wrk_inc_q[i] <= '0;
         end
`ifdef POLY_SYNTH_LINEAR_INTERP_EN
         lo_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         acc_q       <= acc_d;
         en_q        <= en_d;
         wrk_en_q    <= wrk_en_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         phase_q     <= phase_d;
         inc_q       <= inc_d;
         wrk_inc_q   <= wrk_inc_d;
`ifdef POLY_SYNTH_LINEAR_INTERP_EN
         lo_q <= lo_d;
`endif
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_poly_wavetable_synth.sv
// Directed bench for poly_wavetable_synth (4 voices, 24-bit phase, 256x16 table).
module tb_poly_wavetable_synth;

   localparam int NV = 4;
`ifdef POLY_SYNTH_LINEAR_INTERP_EN
   localparam int LAT = 3 * NV + 2;
`else
   localparam int LAT = 2 * NV + 2;
`endif

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        sample_tick = 1'b0;
   logic        voice_we = 1'b0;
   logic [1:0]  voice_sel = '0;
   logic [23:0] voice_freq = '0;
   logic        voice_en = 1'b0;
   logic [15:0] out;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   int n_cmp  = 0;
   int n_fail = 0;
   int valid_cnt = 0;
   int ovr_cnt   = 0;

   poly_wavetable_synth #(
      .NUM_VOICES(NV), .PHASE_W(24), .TABLE_AW(8), .SAMPLE_W(16)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick),
      .voice_we(voice_we), .voice_sel(voice_sel), .voice_freq(voice_freq),
      .voice_en(voice_en), .out(out), .out_valid(out_valid), .busy(busy),
      .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   // Pulse counters, sampled mid-cycle
   always @(negedge Clk) begin
      if (out_valid === 1'b1) valid_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cfg(input int sel, input logic [23:0] f, input logic en);
      voice_we   = 1'b1;
      voice_sel  = 2'(sel);
      voice_freq = f;
      voice_en   = en;
      @(posedge Clk); #1;
      voice_we   = 1'b0;
   endtask

   task automatic pulse_tick();
      sample_tick = 1'b1;
      @(posedge Clk); #1;
      sample_tick = 1'b0;
   endtask

   // Wait for out_valid; n0 = edges already elapsed since the tick edge
   task automatic wait_out(input int n0, output int lat);
      int n = n0;
      while (out_valid !== 1'b1 && n < 60) begin
         @(posedge Clk); #1;
         n++;
      end
      lat = n;
   endtask

   task automatic frame(input string tag, input int exp_out);
      int lat;
      pulse_tick();
      wait_out(0, lat);
      check({tag, "_lat"}, lat, LAT);
      check({tag, "_out"}, $signed(out), exp_out);
   endtask

   initial begin
      int lat;
      int vb;
      int ob;

      // Reset state
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      check("rst_out", $signed(out), 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      frame("rst_first", 0);

      // Single voice, quarter-turn steps: index 0,64,128,192,0
      cfg(0, 24'h400000, 1'b1);
      frame("sv0", 0);
      frame("sv1", 8191);
      frame("sv2", 0);
      frame("sv3", -8192);
      frame("sv4", 0);

      // Full chord: all four at index 64 gives the mixer full scale
      for (int i = 0; i < NV; i++) cfg(i, 24'h0, 1'b0);
      for (int i = 0; i < NV; i++) cfg(i, 24'h400000, 1'b1);
      frame("chord0", 0);
      frame("chord1", 32767);

      // Reset mid-frame aborts and clears everything
      pulse_tick();
      repeat (3) @(posedge Clk);
      #3 Reset_n = 1'b0;
      #1;
      check("mid_rst_out", $signed(out), 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      vb = valid_cnt;
      repeat (15) @(posedge Clk);
      #1;
      check("mid_rst_no_valid", valid_cnt - vb, 0);
      frame("post_rst0", 0);
      frame("post_rst1", 0);

      // Overrun: second tick 4 edges after the first
      cfg(0, 24'h400000, 1'b1);
      vb = valid_cnt;
      ob = ovr_cnt;
      pulse_tick();
      repeat (3) @(posedge Clk);
      #1;
      pulse_tick();
      check("ovr_pulse", overrun, 1);
      repeat (15) @(posedge Clk);
      #1;
      check("ovr_valid_cnt", valid_cnt - vb, 1);
      check("ovr_pulse_cnt", ovr_cnt - ob, 1);
      check("ovr_out", $signed(out), 0);
      frame("ovr_next", 8191);

      // Tick and write on the same edge: snapshot uses the old increment
      cfg(0, 24'h0, 1'b0);
      cfg(0, 24'h400000, 1'b1);
      voice_we    = 1'b1;
      voice_sel   = 2'd0;
      voice_freq  = 24'h800000;
      voice_en    = 1'b1;
      sample_tick = 1'b1;
      @(posedge Clk); #1;
      voice_we    = 1'b0;
      sample_tick = 1'b0;
      wait_out(0, lat);
      check("same_edge_a_lat", lat, LAT);
      check("same_edge_a_out", $signed(out), 0);
      frame("same_edge_b", 8191);
      frame("same_edge_c", -8192);

      // Slow sweep: one table index per frame
      cfg(0, 24'h0, 1'b0);
      cfg(0, 24'h010000, 1'b1);
      for (int k = 0; k < 65; k++) begin
         pulse_tick();
         wait_out(0, lat);
         check("sweep_lat", lat, LAT);
         if (k == 1) check("sweep_idx1", $signed(out), 201);
         if (k == 32) check("sweep_idx32", $signed(out), 5792);
         if (k == 64) check("sweep_idx64", $signed(out), 8191);
      end
      cfg(0, 24'h010000, 1'b0);
      cfg(0, 24'h010000, 1'b1);
      frame("reenable", 0);

      // Mid-frame write to voice 1 takes effect from the next frame
      cfg(0, 24'h0, 1'b0);
      cfg(1, 24'h400000, 1'b1);
      pulse_tick();
      check("mid_wr_busy", busy, 1);
      cfg(1, 24'h800000, 1'b1);
      wait_out(1, lat);
      check("mid_wr_a_lat", lat, LAT);
      check("mid_wr_a_out", $signed(out), 0);
      frame("mid_wr_b", 8191);
      frame("mid_wr_c", -8192);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
